// File: rtl/jtag_tap_param.sv
// IEEE 1149.1 TAP controller: 16-state TCK FSM, IR_WIDTH instruction register,
// BYPASS / IDCODE / USER data registers with parallel capture and update.
module jtag_tap_param #(
    parameter int unsigned IR_WIDTH     = 4,
    parameter int unsigned DR_WIDTH     = 8,
    parameter logic [31:0] IDCODE_VAL   = 32'h1234_5679,
    parameter int unsigned IDCODE_INSTR = 1,
    parameter int unsigned USER_INSTR   = 2
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_EN,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out,
    input  logic [DR_WIDTH-1:0] dr_in,
    output logic [DR_WIDTH-1:0] dr_out,
    output logic                dr_update
);

    // state | meaning
    // TLR   | test-logic-reset (F)     RTI   | run-test/idle (C)
    // SELDR | select-DR scan (7)       SELIR | select-IR scan (4)
    // CAPDR | capture-DR (6)           CAPIR | capture-IR (E)
    // SHDR  | shift-DR (2)             SHIR  | shift-IR (A)
    // EX1DR | exit1-DR (1)             EX1IR | exit1-IR (9)
    // PAUDR | pause-DR (3)             PAUIR | pause-IR (B)
    // EX2DR | exit2-DR (0)             EX2IR | exit2-IR (8)
    // UPDDR | update-DR (5)            UPDIR | update-IR (D)
    typedef enum logic [3:0] {
        EX2DR = 4'h0, EX1DR = 4'h1, SHDR  = 4'h2, PAUDR = 4'h3,
        SELIR = 4'h4, UPDDR = 4'h5, CAPDR = 4'h6, SELDR = 4'h7,
        EX2IR = 4'h8, EX1IR = 4'h9, SHIR  = 4'hA, PAUIR = 4'hB,
        RTI   = 4'hC, UPDIR = 4'hD, CAPIR = 4'hE, TLR   = 4'hF
    } state_e;

    localparam logic [IR_WIDTH-1:0] IR_IDCODE  = IR_WIDTH'(IDCODE_INSTR);
    localparam logic [IR_WIDTH-1:0] IR_USER    = IR_WIDTH'(USER_INSTR);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
    localparam logic [IR_WIDTH-1:0] IR_ONES    = '1;

    state_e state_q, state_d;

    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;
    logic                byp_q, byp_d;
    logic [31:0]         id_sr_q, id_sr_d;
    logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
    logic [DR_WIDTH-1:0] dr_out_q, dr_out_d;
    logic                tdo_q, tdo_d;
    logic                tdo_en_q, tdo_en_d;

    logic in_tlr, cap_ir, sh_ir, upd_ir, cap_dr, sh_dr, upd_dr;
    logic sel_idcode, sel_user, sel_bypass;
    logic tdo_bit;

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state_q <= TLR;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:   state_d = TMS ? TLR   : RTI;
            RTI:   state_d = TMS ? SELDR : RTI;
            SELDR: state_d = TMS ? SELIR : CAPDR;
            CAPDR: state_d = TMS ? EX1DR : SHDR;
            SHDR:  state_d = TMS ? EX1DR : SHDR;
            EX1DR: state_d = TMS ? UPDDR : PAUDR;
            PAUDR: state_d = TMS ? EX2DR : PAUDR;
            EX2DR: state_d = TMS ? UPDDR : SHDR;
            UPDDR: state_d = TMS ? SELDR : RTI;
            SELIR: state_d = TMS ? TLR   : CAPIR;
            CAPIR: state_d = TMS ? EX1IR : SHIR;
            SHIR:  state_d = TMS ? EX1IR : SHIR;
            EX1IR: state_d = TMS ? UPDIR : PAUIR;
            PAUIR: state_d = TMS ? EX2IR : PAUIR;
            EX2IR: state_d = TMS ? UPDIR : SHIR;
            UPDIR: state_d = TMS ? SELDR : RTI;
            default: state_d = TLR;
        endcase
    end

    always_comb begin
        in_tlr    = (state_q == TLR);
        cap_ir    = (state_q == CAPIR);
        sh_ir     = (state_q == SHIR);
        upd_ir    = (state_q == UPDIR);
        cap_dr    = (state_q == CAPDR);
        sh_dr     = (state_q == SHDR);
        upd_dr    = (state_q == UPDDR);
        dr_update = upd_dr && sel_user;
    end

    // All-ones always means BYPASS; IDCODE wins if both opcodes coincide.
    always_comb begin
        sel_idcode = (ir_q != IR_ONES) && (ir_q == IR_IDCODE);
        sel_user   = (ir_q != IR_ONES) && (ir_q == IR_USER) && !sel_idcode;
        sel_bypass = !sel_idcode && !sel_user;
    end

    always_comb begin
        ir_sr_d   = ir_sr_q;
        ir_d      = ir_q;
        byp_d     = byp_q;
        id_sr_d   = id_sr_q;
        user_sr_d = user_sr_q;
        dr_out_d  = dr_out_q;
        if (in_tlr) begin
            ir_sr_d  = IR_IDCODE;
            ir_d     = IR_IDCODE;
            dr_out_d = '0;
        end else begin
            if (cap_ir) ir_sr_d = IR_CAPTURE;
            if (sh_ir)  ir_sr_d = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            if (upd_ir) ir_d    = ir_sr_q;
            if (cap_dr) begin
                if (sel_bypass) byp_d     = 1'b0;
                if (sel_idcode) id_sr_d   = IDCODE_VAL;
                if (sel_user)   user_sr_d = dr_in;
            end
            if (sh_dr) begin
                if (sel_bypass) byp_d     = TDI;
                if (sel_idcode) id_sr_d   = {TDI, id_sr_q[31:1]};
                // Concatenate-and-shift keeps DR_WIDTH==1 legal.
                if (sel_user)   user_sr_d = DR_WIDTH'({TDI, user_sr_q} >> 1);
            end
            if (dr_update) dr_out_d = user_sr_q;
        end
    end

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_sr_q   <= IR_IDCODE;
            ir_q      <= IR_IDCODE;
            byp_q     <= 1'b0;
            id_sr_q   <= '0;
            user_sr_q <= '0;
            dr_out_q  <= '0;
        end else begin
            ir_sr_q   <= ir_sr_d;
            ir_q      <= ir_d;
            byp_q     <= byp_d;
            id_sr_q   <= id_sr_d;
            user_sr_q <= user_sr_d;
            dr_out_q  <= dr_out_d;
        end
    end

    always_comb begin
        if (sh_ir)           tdo_bit = ir_sr_q[0];
        else if (sel_idcode) tdo_bit = id_sr_q[0];
        else if (sel_user)   tdo_bit = user_sr_q[0];
        else                 tdo_bit = byp_q;
    end

    always_comb begin
        tdo_d    = tdo_q;
        tdo_en_d = 1'b0;
        if (in_tlr) begin
            tdo_d = 1'b0;
        end else if (sh_ir || sh_dr) begin
            tdo_d    = tdo_bit;
            tdo_en_d = 1'b1;
        end
    end

    // TDO launches on the falling edge so the board samples it on the next rise.
    always_ff @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO       = tdo_q;
    assign TDO_EN    = tdo_en_q;
    assign tap_state = state_q;
    assign ir_out    = ir_q;
    assign dr_out    = dr_out_q;

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: a state-table/arithmetic model checked every cycle on
// the default instance, plus directed scans on a wide-IR/wide-DR instance.
module tb_jtag_tap_param;

    logic        TCK = 1'b0;
    logic        TRST = 1'b0;
    logic        TMS = 1'b1;
    logic        TDI = 1'b0;
    logic        TDO, TDO_EN, dr_update;
    logic [3:0]  tap_state, ir_out;
    logic [7:0]  dr_in = 8'hA5;
    logic [7:0]  dr_out;

    logic        TDO2, TDO_EN2, dr_update2;
    logic [3:0]  tap_state2;
    logic [4:0]  ir_out2;
    logic [15:0] dr_in2 = 16'hBEEF;
    logic [15:0] dr_out2;

    int pass_cnt = 0;
    int total_cnt = 0;
    int en_cnt = 0;
    bit chk_en = 1'b0;

    jtag_tap_param dut (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
        .tap_state(tap_state), .ir_out(ir_out), .dr_in(dr_in), .dr_out(dr_out),
        .dr_update(dr_update)
    );

    jtag_tap_param #(.IR_WIDTH(5), .DR_WIDTH(16)) dut2 (
        .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO2), .TDO_EN(TDO_EN2),
        .tap_state(tap_state2), .ir_out(ir_out2), .dr_in(dr_in2), .dr_out(dr_out2),
        .dr_update(dr_update2)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model of the default instance ----------------
    int          m_st, m_irsr, m_ir, m_byp;
    logic [31:0] m_id;
    int          m_user, m_dro;
    logic        m_tdo, m_en;

    function automatic int nxt(input int s, input logic t);
        case (s)
            'hF: return t ? 'hF : 'hC;
            'hC: return t ? 'h7 : 'hC;
            'h7: return t ? 'h4 : 'h6;
            'h4: return t ? 'hF : 'hE;
            'h6: return t ? 'h1 : 'h2;
            'hE: return t ? 'h9 : 'hA;
            'h2: return t ? 'h1 : 'h2;
            'hA: return t ? 'h9 : 'hA;
            'h1: return t ? 'h5 : 'h3;
            'h9: return t ? 'hD : 'hB;
            'h3: return t ? 'h0 : 'h3;
            'hB: return t ? 'h8 : 'hB;
            'h0: return t ? 'h5 : 'h2;
            'h8: return t ? 'hD : 'hA;
            default: return t ? 'h7 : 'hC;
        endcase
    endfunction

    // 0 = bypass, 1 = idcode, 2 = user
    function automatic int sel_of(input int ir);
        if (ir == 15) return 0;
        if (ir == 1)  return 1;
        if (ir == 2)  return 2;
        return 0;
    endfunction

    always @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            m_st = 'hF; m_irsr = 1; m_ir = 1; m_dro = 0;
        end else begin
            int s;
            s = sel_of(m_ir);
            case (m_st)
                'hF: begin m_irsr = 1; m_ir = 1; m_dro = 0; end
                'hE: m_irsr = 1;
                'hA: m_irsr = (m_irsr / 2) + (TDI ? 8 : 0);
                'hD: m_ir = m_irsr;
                'h6: begin
                    if (s == 0) m_byp = 0;
                    else if (s == 1) m_id = 32'h1234_5679;
                    else m_user = int'(dr_in);
                end
                'h2: begin
                    if (s == 0) m_byp = TDI ? 1 : 0;
                    else if (s == 1) m_id = (m_id >> 1) | (TDI ? 32'h8000_0000 : 32'h0);
                    else m_user = (m_user / 2) + (TDI ? 128 : 0);
                end
                'h5: if (s == 2) m_dro = m_user;
                default: ;
            endcase
            m_st = nxt(m_st, TMS);
        end
    end

    always @(negedge TCK or negedge TRST) begin
        if (!TRST) begin
            m_tdo = 0; m_en = 0;
        end else if (m_st == 'hF) begin
            m_tdo = 0; m_en = 0;
        end else if (m_st == 'hA) begin
            m_tdo = m_irsr[0]; m_en = 1;
        end else if (m_st == 'h2) begin
            case (sel_of(m_ir))
                1:       m_tdo = m_id[0];
                2:       m_tdo = m_user[0];
                default: m_tdo = m_byp[0];
            endcase
            m_en = 1;
        end else begin
            m_en = 0;
        end
    end

    always @(posedge TCK) begin
        #4;
        if (chk_en && TRST) begin
            chk("tap_state", 32'(tap_state), 32'(m_st));
            chk("ir_out", 32'(ir_out), 32'(m_ir));
            chk("dr_out", 32'(dr_out), 32'(m_dro));
            chk("dr_update", 32'(dr_update), 32'((m_st == 'h5) && (sel_of(m_ir) == 2)));
            chk("TDO_EN", 32'(TDO_EN), 32'(m_en));
            chk("TDO", 32'(TDO), 32'(m_tdo));
        end
    end

    always @(negedge TCK) begin
        #1;
        if (TDO_EN) en_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    task automatic shift(input logic [31:0] data, input int n,
                         output logic [31:0] o0, output logic [31:0] o1);
        o0 = '0;
        o1 = '0;
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, data[i]);
            o0[i] = TDO;
            o1[i] = TDO2;
        end
    endtask

    task automatic ir_scan(input logic [31:0] data, input int n,
                           output logic [31:0] o0, output logic [31:0] o1);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift(data, n, o0, o1);
        step(1, 0); step(0, 0);
    endtask

    task automatic dr_scan(input logic [31:0] data, input int n,
                           output logic [31:0] o0, output logic [31:0] o1);
        step(1, 0); step(0, 0); step(0, 0);
        shift(data, n, o0, o1);
        step(1, 0); step(0, 0);
    endtask

    initial begin
        logic [31:0] o0, o1;
        @(posedge TCK); #1;
        step(1, 0); step(1, 0);
        chk("rst tap_state", 32'(tap_state), 32'hF);
        chk("rst ir_out", 32'(ir_out), 32'h1);
        chk("rst dr_out", 32'(dr_out), 32'h0);
        chk("rst TDO_EN", 32'(TDO_EN), 32'h0);
        chk("rst dr_update", 32'(dr_update), 32'h0);
        chk("rst2 tap_state", 32'(tap_state2), 32'hF);
        chk("rst2 ir_out", 32'(ir_out2), 32'h1);
        chk("rst2 dr_out", 32'(dr_out2), 32'h0);
        chk("rst2 TDO_EN", 32'(TDO_EN2), 32'h0);
        chk("rst2 dr_update", 32'(dr_update2), 32'h0);
        TRST = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("tlr hold", 32'(tap_state), 32'hF);
        step(0, 0);
        chk("rti", 32'(tap_state), 32'hC);

        // IR scan split by a pause
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        shift(32'b0010, 4, o0, o1);
        chk("ir capture bits", o0[3:0], 32'h1);
        for (int i = 0; i < 6; i++) step(0, 0);
        chk("pause ir", 32'(tap_state), 32'hB);
        step(1, 0); step(0, 0);
        shift(32'b0001, 4, o0, o1);
        chk("ir resumed bits", o0[3:0], 32'h2);
        chk("ir_out before upd", 32'(ir_out), 32'h1);
        step(1, 0); step(0, 0);
        chk("ir after pause", 32'(ir_out), 32'h1);

        // IDCODE
        en_cnt = 0;
        dr_scan(32'h0, 32, o0, o1);
        chk("idcode", o0, 32'h1234_5679);
        chk("idcode TDO_EN count", 32'(en_cnt), 32'd32);

        // BYPASS, explicit and unknown opcode
        ir_scan(32'hF, 4, o0, o1);
        chk("ir F", 32'(ir_out), 32'hF);
        dr_scan(32'hD, 4, o0, o1);
        chk("bypass F", o0[3:0], 32'hA);
        ir_scan(32'h7, 4, o0, o1);
        chk("ir 7", 32'(ir_out), 32'h7);
        dr_scan(32'hD, 4, o0, o1);
        chk("bypass 7", o0[3:0], 32'hA);

        // USER with a pause in the middle of the DR scan
        ir_scan(32'h2, 4, o0, o1);
        chk("ir user", 32'(ir_out), 32'h2);
        step(1, 0); step(0, 0); step(0, 0);
        shift(32'h81, 8, o0, o1);
        chk("user capture", o0[7:0], 32'hA5);
        chk("dr_out pre upd", 32'(dr_out), 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0);
        step(1, 0); step(0, 0);
        shift(32'h55, 8, o0, o1);
        chk("user resumed", o0[7:0], 32'h81);
        step(0, 0); step(1, 0); step(1, 0);
        chk("upd state", 32'(tap_state), 32'h5);
        chk("dr_update high", 32'(dr_update), 32'h1);
        chk("dr_out in upd", 32'(dr_out), 32'h0);
        step(0, 0);
        chk("dr_update low", 32'(dr_update), 32'h0);
        chk("dr_out updated", 32'(dr_out), 32'h55);

        // asynchronous reset in the middle of a DR shift
        step(1, 0); step(0, 0); step(0, 0); step(0, 1); step(0, 0);
        TRST = 1'b0;
        #1;
        chk("async state", 32'(tap_state), 32'hF);
        chk("async ir_out", 32'(ir_out), 32'h1);
        chk("async dr_out", 32'(dr_out), 32'h0);
        chk("async TDO_EN", 32'(TDO_EN), 32'h0);
        @(posedge TCK); #1;
        TRST = 1'b1;
        for (int i = 0; i < 5; i++) step(1, 0);
        chk("post rst tlr", 32'(tap_state), 32'hF);
        chk("post rst dr_out", 32'(dr_out), 32'h0);
        step(0, 0);

        // wider instance: 5-bit IR, 16-bit USER
        ir_scan(32'h2, 5, o0, o1);
        chk("w capir", o1[4:0], 32'h01);
        chk("w ir_out", 32'(ir_out2), 32'h2);
        dr_scan(32'hBEEF, 16, o0, o1);
        chk("w user capture", o1[15:0], 32'hBEEF);
        chk("w dr_out", 32'(dr_out2), 32'hBEEF);

        step(1, 0); step(1, 0);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/jtag_tap_param.md
Name: jtag_tap_param

Overview:
Parametrised IEEE 1149.1 TAP controller with a TCK-driven 16-state FSM, an instruction register of width IR_WIDTH, and three data registers: BYPASS (1 bit), IDCODE (32 bits) and USER (DR_WIDTH bits, parallel capture/update). It succeeds the fixed-width ics TAP by adding configurable IR/DR widths, an IDCODE register, parallel user I/O with an update strobe, a TDO output enable, and an exported state code. It sits between the board JTAG pins and on-chip debug/config logic.

Parameters:
IR_WIDTH, 4, instruction register length (>=2)
DR_WIDTH, 8, USER data register length (>=1)
IDCODE_VAL, 32'h1234_5679, IDCODE contents (bit0 must be 1)
IDCODE_INSTR, 1, opcode selecting IDCODE
USER_INSTR, 2, opcode selecting USER DR

Ports:
TCK  in  1  test clock; all logic is clocked by TCK
TRST  in  1  asynchronous, active-low reset
TMS  in  1  mode select, sampled on rising TCK
TDI  in  1  serial data in, sampled on rising TCK
TDO  out  1  serial data out, updated on falling TCK
TDO_EN  out  1  high while TDO carries valid shift data
tap_state  out  4  current FSM state code
ir_out  out  IR_WIDTH  active instruction
dr_in  in  DR_WIDTH  parallel value captured into USER in Capture-DR
dr_out  out  DR_WIDTH  USER update register
dr_update  out  1  one-TCK strobe, high while in Update-DR with USER selected

Behaviour:
- State codes (hex): TLR F, RTI C, SelDR 7, CapDR 6, ShDR 2, Ex1DR 1, PauDR 3, Ex2DR 0, UpdDR 5, SelIR 4, CapIR E, ShIR A, Ex1IR 9, PauIR B, Ex2IR 8, UpdIR D. tap_state is the state register itself.
- Transitions follow the IEEE 1149.1 rules, evaluated on rising TCK:
  - TLR: TMS 0 -> RTI
  - RTI: TMS 1 -> SelDR
  - SelDR: TMS 1 -> SelIR, else -> CapDR
  - SelIR: TMS 1 -> TLR, else -> CapIR
  - Cap: TMS 1 -> Ex1, else -> Sh
  - Sh: TMS 1 -> Ex1
  - Ex1: TMS 1 -> Upd, else -> Pau
  - Pau: TMS 1 -> Ex2
  - Ex2: TMS 1 -> Upd, else -> Sh
  - Upd: TMS 1 -> SelDR, else -> RTI
  - States with no listed TMS value hold on the other value.
- Five consecutive TMS=1 edges reach TLR from any state.
- TRST low (async), and on every rising edge while in TLR:
  - state=F, IR shift and ir_out = IDCODE_INSTR
  - dr_out=0, dr_update=0, TDO=0, TDO_EN=0
- Deasserting TRST mid-scan leaves the FSM in TLR; no partial update is ever applied.
- Instruction decode:
  - ir_out==all ones -> BYPASS
  - ir_out==IDCODE_INSTR -> IDCODE
  - ir_out==USER_INSTR -> USER
  - any other value -> BYPASS
- CapIR: IR shift register loads {0..0,2'b01}.
- CapDR loads the selected DR:
  - BYPASS <- 0
  - IDCODE <- IDCODE_VAL
  - USER <- dr_in
- Shifting (rising edge while in ShIR/ShDR):
  - Shift right: TDI enters the MSB, the LSB leaves.
  - The bit present on the edge that exits Sh (TMS=1) is shifted.
  - Pau/Ex1/Ex2 hold contents; re-entering Sh via Ex2 resumes shifting with no bit lost.
- TDO / TDO_EN (falling TCK):
  - In ShIR/ShDR: TDO <= LSB of the active shift register, TDO_EN <= 1.
  - Otherwise: TDO_EN <= 0 and TDO holds.
- Update:
  - Rising edge while in UpdIR: ir_out <= IR shift register.
  - Rising edge while in UpdDR with USER selected: dr_out <= USER shift register.
  - dr_update = (state==UpdDR && USER selected), combinational from registers: exactly 1 TCK wide.
- The IR shift register and ir_out are separate; ir_out changes only in UpdIR or reset.

Test Plan:
- Reset: TRST low mid-ShDR -> tap_state=F, ir_out=1, dr_out=0, TDO_EN=0 immediately (async); after release, 5 extra TMS=1 edges keep state F.
- IR scan: RTI->ShIR, shift TDI 0,1,0,0 (last bit with TMS=1), PauIR x6, Ex2->ShIR, shift 1,0,0,0, UpdIR -> ir_out=4'h1. First scan must show TDO bits 1,0,0,0 (capture pattern 0001).
- IDCODE: ir_out=1, CapDR, 32 shifts -> TDO emits 0x12345679 LSB-first, TDO_EN high exactly 32 falling edges.
- BYPASS: load IR=4'hF, shift TDI 1,0,1,1 in ShDR -> TDO shows 0 (captured) then 1,0,1, delayed one cycle; also an unknown opcode 4'h7 behaves identically.
- USER with pause: ir_out=2, dr_in=0xA5, CapDR -> first TDO bits 1,0,1,0,0,1,0,1. Then:
  - shift 1,0,0,0,0,0,0,1, PauDR x4, Ex2->ShDR, shift 1,0,1,0,1,0,1,0, PauDR, Ex2->UpdDR -> dr_out=0x55.
  - dr_update high exactly one TCK; dr_out unchanged (0) before UpdDR.
- Parameter sweep: IR_WIDTH=5, DR_WIDTH=16 -> CapIR pattern 00001, USER round-trip of 0xBEEF correct.
